// File: rtl/dsd_dmem_responder.sv
// Data-memory responder for the dsd_processor dmem port: word RAM plus an I/O page
// with a cycle counter, a compare timer, an output port and a ready/valid TX FIFO.
module dsd_dmem_responder #(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] dmem_addr,
    input  logic [15:0] dmem_data_out,
    input  logic        dmem_wr,
    output logic [15:0] dmem_data_in,
    output logic [15:0] io_out_port,
    output logic        timer_irq,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] A_CYCLE  = 16'hFF00;
    localparam logic [15:0] A_TCMP   = 16'hFF01;
    localparam logic [15:0] A_STAT   = 16'hFF02;
    localparam logic [15:0] A_OUT    = 16'hFF03;
    localparam logic [15:0] A_TXDATA = 16'hFF04;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic        wr_p1;
    logic [15:0] addr_p1;
    logic [15:0] data_p1;
    logic        wstb;

    logic [15:0] ram [(1 << RAM_AW)];
    logic        in_ram;
    logic [RAM_AW-1:0] ram_idx;

    logic [15:0] cycle;
    logic [15:0] tcmp;
    logic [15:0] out_port;
    logic        match;
    logic        ovf;
    logic        match_set;

    logic [15:0]      fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    logic sel_cycle, sel_tcmp, sel_stat, sel_out, sel_tx;
    logic [15:0] stat;

    // A store held over several cycles with unchanged address/data acts only once.
    assign wstb = dmem_wr & ~(wr_p1 & (addr_p1 == dmem_addr) & (data_p1 == dmem_data_out));

    always_ff @(posedge clk) begin
        if (!resetn) wr_p1 <= 1'b0;
        else         wr_p1 <= dmem_wr;
    end

    always_ff @(posedge clk) begin
        addr_p1 <= dmem_addr;
        data_p1 <= dmem_data_out;
    end

    assign in_ram  = (dmem_addr >> RAM_AW) == 16'd0;
    assign ram_idx = dmem_addr[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (wstb && in_ram) ram[ram_idx] <= dmem_data_out;
    end

    assign sel_cycle = wstb & (dmem_addr == A_CYCLE);
    assign sel_tcmp  = wstb & (dmem_addr == A_TCMP);
    assign sel_stat  = wstb & (dmem_addr == A_STAT);
    assign sel_out   = wstb & (dmem_addr == A_OUT);
    assign sel_tx    = wstb & (dmem_addr == A_TXDATA);

    assign match_set = (cycle == tcmp) & (tcmp != 16'd0);

    // Sticky flags: a set event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle    <= 16'd0;
            tcmp     <= 16'd0;
            out_port <= 16'd0;
            match    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            cycle <= sel_cycle ? 16'd0 : cycle + 16'd1;
            if (sel_tcmp) tcmp     <= dmem_data_out;
            if (sel_out)  out_port <= dmem_data_out;
            if (match_set)                     match <= 1'b1;
            else if (sel_stat && dmem_data_out[0]) match <= 1'b0;
            if (drop)                          ovf <= 1'b1;
            else if (sel_stat && dmem_data_out[1]) ovf <= 1'b0;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = tx_valid & tx_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push  = sel_tx & (~full | pop);
    assign drop  = sel_tx & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= dmem_data_out;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign tx_valid    = ~empty;
    assign tx_data     = empty ? 16'd0 : fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign timer_irq   = match;
    assign io_out_port = out_port;

    always_comb begin
        stat = 16'd0;
        stat[3:0] = {full, empty, ovf, match};
        stat[4 +: FIFO_AW+1] = count;
    end

    always_comb begin
        dmem_data_in = 16'd0;
        if (in_ram) begin
            dmem_data_in = ram[ram_idx];
        end else begin
            case (dmem_addr)
                A_CYCLE:          dmem_data_in = cycle;
                A_TCMP:           dmem_data_in = tcmp;
                A_STAT, A_TXDATA: dmem_data_in = stat;
                A_OUT:            dmem_data_in = out_port;
                default:          dmem_data_in = 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dsd_dmem_responder.sv
// Scoreboard bench for dsd_dmem_responder: a behavioural memory-map model predicts
// every cycle's outputs and the TX word stream; a monitor compares them at negedge.
module tb_dsd_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] dmem_addr, dmem_data_out, dmem_data_in, io_out_port, tx_data;
    logic        dmem_wr, timer_irq, tx_valid, tx_ready;

    always #5 clk = ~clk;

    dsd_dmem_responder #(.RAM_AW(10), .FIFO_AW(2)) dut (
        .clk(clk), .resetn(resetn),
        .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out), .dmem_wr(dmem_wr),
        .dmem_data_in(dmem_data_in), .io_out_port(io_out_port), .timer_irq(timer_irq),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    typedef struct {
        logic [15:0] rd;
        bit          chk_rd;
        logic [15:0] outp;
        bit          irq;
        bit          vld;
        logic [15:0] txd;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] tx_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    bit          rdy = 0;

    // Reference model state
    logic [15:0] m_ram [1024];
    bit          m_known [1024];
    logic [15:0] m_cycle = 0, m_tcmp = 0, m_out = 0;
    bit          m_match = 0, m_ovf = 0;
    logic [15:0] m_fifo[$];
    bit          m_pwr = 0;
    logic [15:0] m_paddr = 0, m_pdata = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [15:0] m_stat();
        int n = m_fifo.size();
        return 16'(n << 4) | {12'd0, (n == 4), (n == 0), m_ovf, m_match};
    endfunction

    // Drive one cycle, predict its outputs, then advance the model over the clock edge.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input bit w,
                        input bit r, input bit rn);
        exp_t e;
        bit   wstb, pop, push, drop, set;
        int   n;
        dmem_addr = a; dmem_data_out = d; dmem_wr = w; tx_ready = r; resetn = rn;
        e.chk_rd = 1;
        e.rd = 16'd0;
        if (a < 16'd1024) begin
            e.chk_rd = m_known[a[9:0]];
            e.rd = m_ram[a[9:0]];
        end else begin
            case (a)
                16'hFF00: e.rd = m_cycle;
                16'hFF01: e.rd = m_tcmp;
                16'hFF02, 16'hFF04: e.rd = m_stat();
                16'hFF03: e.rd = m_out;
                default:  e.rd = 16'd0;
            endcase
        end
        n = m_fifo.size();
        e.outp = m_out;
        e.irq = m_match;
        e.vld = (n != 0);
        e.txd = (n != 0) ? m_fifo[0] : 16'd0;
        if (chk_en) exp_q.push_back(e);

        wstb = w && !(m_pwr && m_paddr == a && m_pdata == d);
        if (wstb && a < 16'd1024) begin
            m_ram[a[9:0]] = d;
            m_known[a[9:0]] = 1;
        end
        if (!rn) begin
            m_cycle = 0; m_tcmp = 0; m_out = 0; m_match = 0; m_ovf = 0;
            m_fifo.delete();
            tx_q.delete();
        end else begin
            pop  = (n != 0) && r;
            push = wstb && a == 16'hFF04 && (n < 4 || pop);
            drop = wstb && a == 16'hFF04 && n == 4 && !pop;
            set  = (m_cycle == m_tcmp) && (m_tcmp != 0);
            if (set) m_match = 1;
            else if (wstb && a == 16'hFF02 && d[0]) m_match = 0;
            if (drop) m_ovf = 1;
            else if (wstb && a == 16'hFF02 && d[1]) m_ovf = 0;
            m_cycle = (wstb && a == 16'hFF00) ? 16'd0 : m_cycle + 16'd1;
            if (wstb && a == 16'hFF01) m_tcmp = d;
            if (wstb && a == 16'hFF03) m_out = d;
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                m_fifo.push_back(d);
                tx_q.push_back(d);
            end
        end
        m_pwr = rn ? w : 1'b0;
        m_paddr = a;
        m_pdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] a, input int cycles);
        repeat (cycles) step(a, 16'h0, 0, rdy, 1);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input int hold);
        repeat (hold) step(a, d, 1, rdy, 1);
        step(a, 16'h0, 0, rdy, 1);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom % 4)
            0: return 16'($urandom_range(0, 15));
            1: return 16'hFF00 + 16'($urandom_range(0, 6));
            2: return 16'($urandom_range(1020, 1030));
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: per-cycle output comparison plus in-order TX stream check.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) check("dmem_data_in", dmem_data_in, e.rd);
            check("io_out_port", io_out_port, e.outp);
            check("timer_irq", {15'd0, timer_irq}, {15'd0, e.irq});
            check("tx_valid", {15'd0, tx_valid}, {15'd0, e.vld});
            check("tx_data", tx_data, e.txd);
        end
        if (resetn === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_q.size() == 0) check("tx_stream_extra", tx_data, 16'hxxxx);
            else check("tx_stream", tx_data, tx_q.pop_front());
        end
    end

    initial begin
        logic [15:0] a, d;
        bit w, r;

        step(16'h0, 16'h0, 0, 0, 0);
        step(16'h0, 16'h0, 0, 0, 0);
        chk_en = 1;

        // Held store acts once; unmapped read returns 0
        store(16'h0012, 16'hBEEF, 3);
        idle(16'h0012, 1);
        idle(16'h2000, 1);

        // Cycle counter and clear-on-write
        idle(16'hFF00, 10);
        store(16'hFF00, 16'h1234, 1);
        idle(16'hFF00, 3);

        // Timer match, write-1-to-clear, and clear coinciding with a match
        store(16'hFF01, 16'h0020, 1);
        store(16'hFF00, 16'h0000, 1);
        idle(16'hFF02, 36);
        store(16'hFF02, 16'h0001, 1);
        idle(16'hFF02, 2);
        store(16'hFF01, 16'h0003, 1);
        step(16'hFF00, 16'h0, 1, rdy, 1);
        step(16'hFF02, 16'h3, 1, rdy, 1);
        idle(16'hFF02, 2);
        step(16'hFF02, 16'h3, 1, rdy, 1);
        idle(16'hFF02, 3);
        store(16'hFF01, 16'h0000, 1);
        store(16'hFF02, 16'h0003, 1);

        // Overflow with consumer stalled, then drain
        rdy = 0;
        store(16'hFF04, 16'h1111, 1);
        store(16'hFF04, 16'h2222, 1);
        store(16'hFF04, 16'h3333, 1);
        store(16'hFF04, 16'h4444, 1);
        store(16'hFF04, 16'h5555, 1);
        idle(16'hFF02, 1);
        rdy = 1;
        idle(16'hFF04, 6);

        // Full FIFO with simultaneous pop accepts the push
        rdy = 0;
        store(16'hFF02, 16'h0002, 1);
        store(16'hFF04, 16'hA001, 1);
        store(16'hFF04, 16'hA002, 1);
        store(16'hFF04, 16'hA003, 1);
        store(16'hFF04, 16'hA004, 1);
        step(16'hFF04, 16'h6666, 1, 1, 1);
        rdy = 1;
        idle(16'hFF02, 6);

        // Reset mid-operation flushes I/O but keeps RAM
        rdy = 0;
        store(16'hFF04, 16'hAAAA, 1);
        store(16'hFF04, 16'hBBBB, 1);
        store(16'hFF03, 16'h00FF, 1);
        store(16'h0005, 16'h1234, 1);
        step(16'h0005, 16'h0, 0, 0, 0);
        idle(16'h0005, 1);
        idle(16'hFF02, 1);
        idle(16'hFF00, 1);

        // Randomised traffic with held stores and occasional resets
        a = 16'h0; d = 16'h0; w = 0; r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) >= 30) begin
                a = rand_addr();
                d = ($urandom % 2) ? 16'($urandom_range(0, 63)) : 16'($urandom);
                w = ($urandom_range(0, 99) < 45);
            end
            r = ($urandom_range(0, 99) < 40);
            step(a, d, w, r, ($urandom_range(0, 299) != 0));
        end

        // Counter wraps back to the same value after 65536 cycles
        rdy = 0;
        idle(16'hFF00, 65540);

        rdy = 1;
        idle(16'hFF02, 8);
        check("tx_stream_drained", 16'(tx_q.size()), 16'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
